// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes,
// receiver state encoding and bit-centre helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  function automatic int mid_of(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchronizer, start-edge detect, bit counter, 3-sample vote.
// Ports: clk_i, rst_ni, rx_i, clr_i -> start_o, vld_o, bit_o, line_o, last_o.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  input  logic clr_i,
  output logic start_o,
  output logic vld_o,
  output logic bit_o,
  output logic line_o,
  output logic last_o
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = mid_of(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] C_S1   = CW'(MID);
  localparam logic [CW-1:0] C_S2   = CW'(MID + 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic          prev_q;
  logic          start_q;
  logic          s0_q;
  logic          s1_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // fill_q keeps the edge register at 0 until the synchronizer
  // holds real line data, so a line low out of reset is no start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      prev_q  <= 1'b0;
      start_q <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= sync_q[1] & fill_q[1];
      start_q <= prev_q & ~sync_q[1];
      cnt_q   <= cnt_d;
      if (cnt_q == C_S0) s0_q <= sync_q[1];
      if (cnt_q == C_S1) s1_q <= sync_q[1];
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == C_LAST) cnt_d = '0;
  end

  assign start_o = start_q;
  assign vld_o   = (cnt_q == C_S2);
  assign last_o  = (cnt_q == C_LAST);
  assign line_o  = sync_q[1];
  assign bit_o   = (s0_q & s1_q)
                 | (s0_q & sync_q[1])
                 | (s1_q & sync_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity, stop bits, error flags.
// Ports: i_Clock, i_Rst_L, i_RX_Serial -> o_RX_DV, o_RX_Byte, flags, o_RX_Busy.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_RX_Busy
);

  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam logic       PODD  = (PARITY == PARITY_ODD);

  rx_state_e state_q, state_d;

  logic start, vld, vbit, line, last, clr, done;

  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           idx_q;
  logic                 px_q, perr_q, ferr_q, zero_q;

  logic                 dv_q, pe_q, fe_q, brk_q;
  logic [DATA_BITS-1:0] byte_q;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_smp (
    .clk_i  (i_Clock),
    .rst_ni (i_Rst_L),
    .rx_i   (i_RX_Serial),
    .clr_i  (clr),
    .start_o(start),
    .vld_o  (vld),
    .bit_o  (vbit),
    .line_o (line),
    .last_o (last)
  );

  assign done = (state_q == S_STOP) && vld && (idx_q == SLAST);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_START;
      S_START:
        if (vld && vbit) state_d = S_IDLE;
        else if (last)   state_d = S_DATA;
      S_DATA:
        if (last && idx_q == DLAST)
          state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
      S_PARITY:
        if (last) state_d = S_STOP;
      S_STOP:
        if (done)
          state_d = (ferr_q || !vbit) ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH:
        if (line) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_RX_Busy = (state_q != S_IDLE);
    clr       = (state_d != state_q);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shift_q <= '0;
      idx_q   <= '0;
      px_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      dv_q <= done;
      unique case (state_q)
        S_IDLE: begin
          idx_q  <= '0;
          px_q   <= 1'b0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
          zero_q <= 1'b1;
        end
        S_DATA: begin
          if (vld) begin
            shift_q <= {vbit, shift_q[DATA_BITS-1:1]};
            px_q    <= px_q ^ vbit;
            zero_q  <= zero_q & ~vbit;
          end
          if (last)
            idx_q <= (idx_q == DLAST) ? 4'd0 : idx_q + 4'd1;
        end
        S_PARITY: begin
          if (vld) begin
            perr_q <= vbit ^ px_q ^ PODD;
            zero_q <= zero_q & ~vbit;
          end
        end
        S_STOP: begin
          if (vld) begin
            ferr_q <= ferr_q | ~vbit;
            zero_q <= zero_q & ~vbit;
          end
          if (last) idx_q <= idx_q + 4'd1;
        end
        default: ;
      endcase
      // Outputs and flags update together, one cycle after the last vote.
      if (done) begin
        byte_q <= shift_q;
        pe_q   <= perr_q;
        fe_q   <= ferr_q | ~vbit;
        brk_q  <= zero_q & ~vbit;
      end
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = pe_q;
  assign o_Frame_Err  = fe_q;
  assign o_Break      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three configurations,
// directed vectors, corner sequences and randomized frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB = 217;
  localparam int MID = CPB / 2;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_ab, rst_c;
  logic [2:0] rx;
  logic [2:0] dv, pe, fe, bk, bz;
  logic [7:0] by_a, by_b;
  logic [6:0] by_c;

  int cyc = 0;
  always @(posedge clk) cyc++;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Rst_L(rst_ab), .i_RX_Serial(rx[0]),
    .o_RX_DV(dv[0]), .o_RX_Byte(by_a), .o_Parity_Err(pe[0]),
    .o_Frame_Err(fe[0]), .o_Break(bk[0]), .o_RX_Busy(bz[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Rst_L(rst_ab), .i_RX_Serial(rx[1]),
    .o_RX_DV(dv[1]), .o_RX_Byte(by_b), .o_Parity_Err(pe[1]),
    .o_Frame_Err(fe[1]), .o_Break(bk[1]), .o_RX_Busy(bz[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Rst_L(rst_c), .i_RX_Serial(rx[2]),
    .o_RX_DV(dv[2]), .o_RX_Byte(by_c), .o_Parity_Err(pe[2]),
    .o_Frame_Err(fe[2]), .o_Break(bk[2]), .o_RX_Busy(bz[2]));

  typedef struct {
    int         cyc;
    logic [8:0] b;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  rec_t q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    if (dv[0]) q0.push_back('{cyc, {1'b0, by_a}, pe[0], fe[0], bk[0]});
    if (dv[1]) q1.push_back('{cyc, {1'b0, by_b}, pe[1], fe[1], bk[1]});
    if (dv[2]) q2.push_back('{cyc, {2'b0, by_c}, pe[2], fe[2], bk[2]});
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dbits(input int s);
    return (s == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int s);
    return s;
  endfunction
  function automatic int sbits(input int s);
    return (s == 2) ? 2 : 1;
  endfunction
  function automatic int nbits(input int s);
    return 1 + dbits(s) + ((pmode(s) != 0) ? 1 : 0) + sbits(s);
  endfunction

  function automatic logic [15:0] mkframe(input int s, input logic [8:0] d,
                                          input logic pb, input logic [1:0] st);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < dbits(s); i++) begin f[k] = d[i]; k++; end
    if (pmode(s) != 0) begin f[k] = pb; k++; end
    for (int i = 0; i < sbits(s); i++) begin f[k] = st[i]; k++; end
    return f;
  endfunction

  // Expected result of one frame from the line-level frame description.
  function automatic rec_t model(input int s, input int t0, input logic [8:0] d,
                                 input logic pb, input logic [1:0] st);
    rec_t r;
    int ones, lows;
    logic [8:0] dm;
    dm = d & 9'((1 << dbits(s)) - 1);
    ones = 0;
    for (int i = 0; i < 9; i++) ones += dm[i];
    lows = 0;
    for (int i = 0; i < sbits(s); i++) lows += (st[i] == 1'b0) ? 1 : 0;
    r.cyc = t0 + 3 + (nbits(s) - 1) * CPB + MID + 2;
    r.b   = dm;
    r.pe  = 1'b0;
    if (pmode(s) == 1) r.pe = (pb != ((ones % 2) == 1));
    if (pmode(s) == 2) r.pe = (pb != ((ones % 2) == 0));
    r.fe  = (lows > 0);
    r.bk  = (dm == 0) && (pmode(s) == 0 || pb == 1'b0) && (lows == sbits(s));
    return r;
  endfunction

  task automatic drive(input int s, input logic [15:0] f, input int n,
                       input int g, output int t0);
    @(negedge clk);
    t0 = cyc + 1;
    for (int k = 0; k < n * CPB; k++) begin
      rx[s] = f[k / CPB] ^ (k == g);
      @(negedge clk);
    end
    rx[s] = 1'b1;
  endtask

  task automatic take(input int s, output int cnt, output rec_t r);
    r = '{0, 9'd0, 1'b0, 1'b0, 1'b0};
    case (s)
      0: begin cnt = q0.size(); if (cnt > 0) r = q0.pop_front(); q0.delete(); end
      1: begin cnt = q1.size(); if (cnt > 0) r = q1.pop_front(); q1.delete(); end
      default: begin
        cnt = q2.size(); if (cnt > 0) r = q2.pop_front(); q2.delete();
      end
    endcase
  endtask

  task automatic check_frame(input string nm, input int s, input rec_t e);
    int   cnt;
    rec_t r;
    take(s, cnt, r);
    chk({nm, " pulses"}, cnt, 1);
    if (cnt > 0) begin
      chk({nm, " latency"}, r.cyc, e.cyc);
      chk({nm, " byte"},    r.b,   e.b);
      chk({nm, " par_err"}, r.pe,  e.pe);
      chk({nm, " frm_err"}, r.fe,  e.fe);
      chk({nm, " break"},   r.bk,  e.bk);
    end
  endtask

  typedef struct {
    int         s;
    logic [8:0] d;
    logic       pb;
    logic [1:0] st;
    logic [8:0] eb;
    logic       epe;
    logic       efe;
    logic       ebk;
  } vec_t;

  vec_t tv[10];

  initial begin
    int   t0, cnt;
    rec_t e, r;
    logic [15:0] f;

    tv[0] = '{0, 9'h3F, 1'b0, 2'b11, 9'h3F, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1, 9'hA5, 1'b1, 2'b11, 9'hA5, 1'b1, 1'b0, 1'b0};
    tv[2] = '{1, 9'hA5, 1'b0, 2'b11, 9'hA5, 1'b0, 1'b0, 1'b0};
    tv[3] = '{0, 9'h55, 1'b0, 2'b00, 9'h55, 1'b0, 1'b1, 1'b0};
    tv[4] = '{0, 9'h12, 1'b0, 2'b11, 9'h12, 1'b0, 1'b0, 1'b0};
    tv[5] = '{2, 9'h2A, 1'b0, 2'b11, 9'h2A, 1'b0, 1'b0, 1'b0};
    tv[6] = '{2, 9'h2A, 1'b1, 2'b11, 9'h2A, 1'b1, 1'b0, 1'b0};
    tv[7] = '{2, 9'h43, 1'b0, 2'b01, 9'h43, 1'b0, 1'b1, 1'b0};
    tv[8] = '{1, 9'h00, 1'b0, 2'b00, 9'h00, 1'b0, 1'b1, 1'b1};
    tv[9] = '{1, 9'h00, 1'b1, 2'b00, 9'h00, 1'b1, 1'b1, 1'b0};

    rx = 3'b111;
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset dv",    int'(dv),   0);
    chk("reset flags", int'({pe, fe, bk}), 0);
    chk("reset busy",  int'(bz),   0);
    chk("reset bytes", int'({by_a, by_b, by_c}), 0);
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    repeat (10) @(negedge clk);

    foreach (tv[i]) begin
      f = mkframe(tv[i].s, tv[i].d, tv[i].pb, tv[i].st);
      drive(tv[i].s, f, nbits(tv[i].s), -1, t0);
      repeat (40) @(negedge clk);
      e = model(tv[i].s, t0, tv[i].d, tv[i].pb, tv[i].st);
      e.b  = tv[i].eb;
      e.pe = tv[i].epe;
      e.fe = tv[i].efe;
      e.bk = tv[i].ebk;
      check_frame($sformatf("vec%0d", i), tv[i].s, e);
    end

    // False start: 50 low cycles, busy timing, no pulse.
    @(negedge clk);
    rx[0] = 1'b0;
    t0 = cyc + 1;
    repeat (3) @(negedge clk);
    chk("fstart busy t0+2", int'(bz[0]), 0);
    @(negedge clk);
    chk("fstart busy t0+3", int'(bz[0]), 1);
    repeat (46) @(negedge clk);
    rx[0] = 1'b1;
    repeat (300) @(negedge clk);
    take(0, cnt, r);
    chk("fstart pulses", cnt, 0);
    chk("fstart busy end", int'(bz[0]), 0);

    // One-cycle spike in the middle of data bit 0.
    f = mkframe(0, 9'h00, 1'b0, 2'b11);
    drive(0, f, nbits(0), CPB + MID + 2, t0);
    repeat (40) @(negedge clk);
    check_frame("glitch", 0, model(0, t0, 9'h00, 1'b0, 2'b11));

    // Break: 12 bit periods low, exactly one pulse.
    @(negedge clk);
    rx[0] = 1'b0;
    t0 = cyc + 1;
    repeat (12 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_frame("break", 0, model(0, t0, 9'h00, 1'b0, 2'b00));
    repeat (CPB) @(negedge clk);
    take(0, cnt, r);
    chk("break extra pulses", cnt, 0);

    // Reset during data bit 3, line left low across release.
    f = mkframe(2, 9'h43, 1'b0, 2'b11);
    @(negedge clk);
    for (int k = 0; k < 4 * CPB + MID; k++) begin
      rx[2] = f[k / CPB];
      @(negedge clk);
    end
    rst_c = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst dv",    int'(dv[2]), 0);
    chk("rst byte",  int'(by_c),  0);
    chk("rst flags", int'({pe[2], fe[2], bk[2]}), 0);
    chk("rst busy",  int'(bz[2]), 0);
    rst_c = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    take(2, cnt, r);
    chk("rst pulses", cnt, 0);
    chk("rst low busy", int'(bz[2]), 0);
    rx[2] = 1'b1;
    repeat (50) @(negedge clk);
    drive(2, f, nbits(2), -1, t0);
    repeat (40) @(negedge clk);
    check_frame("after rst", 2, model(2, t0, 9'h43, 1'b0, 2'b11));

    // Randomized frames against the reference model.
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 3; j++) begin
        logic [8:0] d;
        logic [1:0] st;
        logic       pb;
        int         ones;
        d = 9'($urandom);
        ones = 0;
        for (int b = 0; b < dbits(s); b++) ones += d[b];
        pb = (s == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if ($urandom_range(0, 3) == 0) pb = ~pb;
        st[0] = ($urandom_range(0, 7) != 0);
        st[1] = ($urandom_range(0, 7) != 0);
        f = mkframe(s, d, pb, st);
        drive(s, f, nbits(s), -1, t0);
        repeat (40 + $urandom_range(0, 20)) @(negedge clk);
        check_frame($sformatf("rand s%0d n%0d", s, j), s,
                    model(s, t0, d, pb, st));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
